// File: rtl/modulo_mux8_1_scan_pkg.sv
// Shared definitions for the 8:1 scanning multiplexer: state encoding,
// channel count and the select-to-bit mapping.
package modulo_mux8_1_scan_pkg;

    localparam int NUM_CHANNELS = 8;
    localparam int SEL_W        = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Channel order is mirrored relative to the 1:8 demux: select s drives bit 7-s.
    function automatic logic [SEL_W-1:0] bit_index(input logic [SEL_W-1:0] sel);
        return SEL_W'(NUM_CHANNELS - 1) - sel;
    endfunction

endpackage

// File: rtl/modulo_contador_div.sv
// Dwell counter: counts 0..TICK_DIV-1 while enabled and flags the last count.
module modulo_contador_div #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal ? '0 : count + CNT_W'(1);
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/modulo_mux8_1_scan.sv
// Walks an 8:1 mux across all channels once per start request, dwelling
// TICK_DIV cycles on each and capturing the selected bit into output_word.
module modulo_mux8_1_scan
    import modulo_mux8_1_scan_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic             input_clk,
    input  logic             input_rst_n,
    input  logic             input_start,
    input  logic [7:0]       input_data,
    output logic [SEL_W-1:0] output_sel,
    output logic             output_bit,
    output logic             output_valid,
    output logic [7:0]       output_word,
    output logic             output_busy,
    output logic             output_done
);

    scan_state_t      state;
    logic             tick;
    logic [SEL_W-1:0] bit_idx;
    logic             mux_bit;

    assign bit_idx = bit_index(output_sel);

    modulo_contador_div #(
        .TICK_DIV (TICK_DIV)
    ) u_dwell (
        .clk      (input_clk),
        .rst_n    (input_rst_n),
        .clear    (state != SCAN),
        .enable   (state == SCAN),
        .terminal (tick)
    );

    always_comb begin
        mux_bit = 1'b0;
        case (output_sel)
            3'd0: mux_bit = input_data[7];
            3'd1: mux_bit = input_data[6];
            3'd2: mux_bit = input_data[5];
            3'd3: mux_bit = input_data[4];
            3'd4: mux_bit = input_data[3];
            3'd5: mux_bit = input_data[2];
            3'd6: mux_bit = input_data[1];
            3'd7: mux_bit = input_data[0];
            default: mux_bit = 1'b0;
        endcase
    end

    assign output_bit   = (state == SCAN) ? mux_bit : 1'b0;
    assign output_valid = (state == SCAN) && tick;
    assign output_busy  = (state != IDLE);
    assign output_done  = (state == DONE);

    // The select saturates at the last channel; DONE returns it to channel 0.
    always_ff @(posedge input_clk) begin
        if (!input_rst_n) begin
            state       <= IDLE;
            output_sel  <= '0;
            output_word <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    output_sel <= '0;
                    if (input_start) begin
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (tick) begin
                        output_word[bit_idx] <= input_data[bit_idx];
                        if (output_sel == SEL_W'(NUM_CHANNELS - 1)) begin
                            state <= DONE;
                        end else begin
                            output_sel <= output_sel + SEL_W'(1);
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    output_sel <= '0;
                end
                default: begin
                    state      <= IDLE;
                    output_sel <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modulo_mux8_1_scan.sv
// Scoreboard bench: two scanners (dwell 1 and dwell 3) driven with directed
// and random data, each capture and completion checked against a queued model.
module tb_modulo_mux8_1_scan;

    typedef struct {
        int         inst;
        bit         is_done;
        int         when;
        logic [2:0] sel;
        logic       bitv;
        logic [7:0] word;
    } exp_t;

    logic       clk;
    logic       rst_n   [2];
    logic       start   [2];
    logic [7:0] data    [2];
    logic [2:0] sel_o   [2];
    logic       bit_o   [2];
    logic       valid_o [2];
    logic [7:0] word_o  [2];
    logic       busy_o  [2];
    logic       done_o  [2];

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] sched [0:31];

    modulo_mux8_1_scan #(.TICK_DIV(1)) dut1 (
        .input_clk    (clk),
        .input_rst_n  (rst_n[0]),
        .input_start  (start[0]),
        .input_data   (data[0]),
        .output_sel   (sel_o[0]),
        .output_bit   (bit_o[0]),
        .output_valid (valid_o[0]),
        .output_word  (word_o[0]),
        .output_busy  (busy_o[0]),
        .output_done  (done_o[0])
    );

    modulo_mux8_1_scan #(.TICK_DIV(3)) dut3 (
        .input_clk    (clk),
        .input_rst_n  (rst_n[1]),
        .input_start  (start[1]),
        .input_data   (data[1]),
        .output_sel   (sel_o[1]),
        .output_bit   (bit_o[1]),
        .output_valid (valid_o[1]),
        .output_word  (word_o[1]),
        .output_busy  (busy_o[1]),
        .output_done  (done_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: channel c is captured at scan offset c*T+T-1 from whatever data is
    // on the lines then; completion follows 8*T scan cycles after the start edge.
    task automatic applyStimulus(input int inst, input int tdiv, input bit retrig, input int abort_at);
        int         e_cyc;
        logic [7:0] w;
        exp_t       x;
        e_cyc = cyc + 1;
        w     = 8'h00;
        for (int c = 0; c < 8; c++) begin
            int off;
            off      = c * tdiv + tdiv - 1;
            w[7 - c] = sched[off][7 - c];
            if (abort_at < 0 || off <= abort_at) begin
                x.inst    = inst;
                x.is_done = 1'b0;
                x.when    = e_cyc + off;
                x.sel     = 3'(c);
                x.bitv    = sched[off][7 - c];
                x.word    = 8'h00;
                sb.push_back(x);
            end
        end
        if (abort_at < 0) begin
            x.inst    = inst;
            x.is_done = 1'b1;
            x.when    = e_cyc + 8 * tdiv;
            x.sel     = 3'd7;
            x.bitv    = 1'b0;
            x.word    = w;
            sb.push_back(x);
        end
        start[inst] = 1'b1;
        for (int k = 0; k <= 8 * tdiv; k++) begin
            @(posedge clk); #1;
            start[inst] = retrig && (k == 2 || k == 8 * tdiv);
            data[inst]  = sched[k];
            if (k == abort_at) begin
                rst_n[inst] = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        start[inst] = 1'b0;
    endtask

    task automatic checkIdle(input int inst);
        checkOutput("idle_busy", busy_o[inst], 0);
        checkOutput("idle_sel", sel_o[inst], 0);
        checkOutput("idle_done", done_o[inst], 0);
        checkOutput("idle_valid", valid_o[inst], 0);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (valid_o[i] === 1'b1 || done_o[i] === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_event: inst %0d valid %0b done %0b required none (cycle %0d)",
                             i, valid_o[i], done_o[i], cyc);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("event_inst", i, mon_e.inst);
                    checkOutput("event_kind", done_o[i], mon_e.is_done);
                    checkOutput("event_cycle", cyc, mon_e.when);
                    if (mon_e.is_done) begin
                        checkOutput("done_valid_low", valid_o[i], 0);
                        checkOutput("done_word", word_o[i], mon_e.word);
                    end else begin
                        checkOutput("capture_sel", sel_o[i], mon_e.sel);
                        checkOutput("capture_bit", bit_o[i], mon_e.bitv);
                    end
                end
            end
            if (busy_o[i] === 1'b0) begin
                checkOutput("idle_bit_zero", bit_o[i], 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int inst;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0;
            start[i] = 1'b0;
            data[i]  = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_sel", sel_o[i], 0);
            checkOutput("reset_word", word_o[i], 8'h00);
            checkOutput("reset_valid", valid_o[i], 0);
            checkOutput("reset_busy", busy_o[i], 0);
            checkOutput("reset_done", done_o[i], 0);
            checkOutput("reset_bit", bit_o[i], 0);
            rst_n[i] = 1'b1;
        end
        @(posedge clk); #1;

        $display("[TB] dwell 1, data A5 held");
        for (int k = 0; k < 32; k++) sched[k] = 8'hA5;
        applyStimulus(0, 1, 1'b0, -1);
        checkIdle(0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("word_hold_a5", word_o[0], 8'hA5);

        $display("[TB] dwell 3, data 3C held");
        for (int k = 0; k < 32; k++) sched[k] = 8'h3C;
        applyStimulus(1, 3, 1'b0, -1);
        checkIdle(1);
        checkOutput("word_3c", word_o[1], 8'h3C);

        $display("[TB] data FF then 00 after channel 3");
        for (int k = 0; k < 32; k++) sched[k] = (k <= 3) ? 8'hFF : 8'h00;
        applyStimulus(0, 1, 1'b0, -1);
        checkOutput("word_f0", word_o[0], 8'hF0);

        $display("[TB] start re-pulsed during scan and done");
        for (int k = 0; k < 32; k++) sched[k] = 8'($urandom);
        applyStimulus(0, 1, 1'b1, -1);
        checkIdle(0);
        for (int k = 0; k < 32; k++) sched[k] = 8'($urandom);
        applyStimulus(1, 3, 1'b1, -1);
        checkIdle(1);

        $display("[TB] reset while channel 4 selected");
        for (int k = 0; k < 32; k++) sched[k] = 8'hFF;
        applyStimulus(0, 1, 1'b0, 4);
        checkOutput("abort_sel", sel_o[0], 0);
        checkOutput("abort_word", word_o[0], 8'h00);
        checkOutput("abort_busy", busy_o[0], 0);
        checkOutput("abort_valid", valid_o[0], 0);
        rst_n[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort_stays_idle", busy_o[0], 0);

        $display("[TB] start and reset on the same edge");
        rst_n[1] = 1'b0;
        start[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        rst_n[1] = 1'b1;
        checkOutput("rst_prio_busy", busy_o[1], 0);
        checkOutput("rst_prio_sel", sel_o[1], 0);
        @(posedge clk); #1;
        checkOutput("rst_prio_busy_next", busy_o[1], 0);

        $display("[TB] random scans");
        for (int n = 0; n < 8; n++) begin
            inst = int'($urandom_range(0, 1));
            for (int k = 0; k < 32; k++) sched[k] = 8'($urandom);
            applyStimulus(inst, (inst == 1) ? 3 : 1, 1'($urandom_range(0, 1)), -1);
            checkIdle(inst);
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modulo_mux8_1_scan.md
MODULO_MUX8_1_SCAN -- requirements
Module: modulo_mux8_1_scan

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1: number of clock cycles each channel is selected (dwell), legal range 1..256.
REQ-002 SHALL have port input_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port input_rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port input_start, input, 1: single-cycle request to begin one 8-channel scan.
REQ-005 SHALL have port input_data, input, 8: parallel channel lines; bit order is the inverse of the 1:8 demux (select s maps to bit 7-s).
REQ-006 SHALL have port output_sel, output, 3: currently selected channel index.
REQ-007 SHALL have port output_bit, output, 1: combinational value input_data[7-output_sel] while scanning, otherwise 0.
REQ-008 SHALL have port output_valid, output, 1: high on the capture cycle of the current channel.
REQ-009 SHALL have port output_word, output, 8: register holding the bits captured during the last scan.
REQ-010 SHALL have port output_busy, output, 1: high in states SCAN and DONE.
REQ-011 SHALL have port output_done, output, 1: one-cycle pulse when a scan completes.

Function
REQ-012 SHALL implement the FSM states IDLE, SCAN and DONE.
REQ-013 In IDLE, input_start=1 SHALL cause the transition to SCAN at the next edge, load output_sel=0 and clear the dwell counter.
REQ-014 In SCAN, the dwell counter SHALL count 0..TICK_DIV-1, and output_valid SHALL be high exactly while the count equals TICK_DIV-1.
REQ-015 On each edge where output_valid=1, output_word[7-output_sel] SHALL load input_data[7-output_sel], and the other bits of output_word SHALL hold.
REQ-016 On each edge where output_valid=1 and output_sel<7, output_sel SHALL increment by 1 and the dwell counter SHALL reset to 0.
REQ-017 On the edge where output_valid=1 and output_sel=7, the FSM SHALL go to DONE, and output_sel SHALL hold at 7; output_sel never wraps.
REQ-018 DONE SHALL last exactly one cycle with output_done=1 and output_valid=0, then go to IDLE, which sets output_sel=0.
REQ-019 Total latency SHALL be 8*TICK_DIV SCAN cycles plus 1 DONE cycle after the start edge; with TICK_DIV=1, start sampled at edge 0 gives SCAN in cycles 1..8 and DONE in cycle 9.
REQ-020 input_start SHALL be ignored while in SCAN or DONE; there is no queuing or restart.
REQ-021 input_start asserted on the same edge as DONE->IDLE SHALL be ignored; a new scan needs start sampled in IDLE.
REQ-022 Changes on input_data between capture cycles SHALL NOT affect output_word; only the value present on each channel's capture cycle is stored.
REQ-023 output_word SHALL hold its value after DONE until the next scan overwrites it bit by bit.
REQ-024 The dwell counter width SHALL be max(1, clog2(TICK_DIV)) bits and SHALL never exceed TICK_DIV-1.

Reset
REQ-025 While input_rst_n=0 at a rising edge, the block SHALL set state=IDLE, output_sel=0, dwell counter=0 and output_word=8'h00.
REQ-026 Following reset, output_valid, output_busy and output_done SHALL be 0, and output_bit SHALL be 0.
REQ-027 Reset asserted mid-scan SHALL abort the scan and discard the partially captured word, with no output_done pulse.
REQ-028 Reset SHALL take priority over input_start on the same edge.

Structure
REQ-029 The state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2), channel count 8 and select width 3 SHALL live in the shared project package.
REQ-030 The dwell counter SHALL be a separate sub-module, modulo_contador_div, parameterised by TICK_DIV, with inputs clk, rst_n, clear and enable and a terminal-count output.
REQ-031 The 8:1 selection SHALL be a plain combinational mux inside modulo_mux8_1_scan.

Verification
REQ-032 Bench SHALL cover: TICK_DIV=1, input_data=8'hA5 held, start pulse -> output_valid high 8 consecutive cycles, output_sel 0..7, output_bit sequence 1,0,1,0,0,1,0,1, output_done in cycle 9, output_word=8'hA5.
REQ-033 Bench SHALL cover: TICK_DIV=3, input_data=8'h3C -> each output_sel held 3 cycles, output_valid on the 3rd cycle only, output_done 25 cycles after start, output_word=8'h3C.
REQ-034 Bench SHALL cover: TICK_DIV=1, input_data changes 8'hFF->8'h00 after channel 3 captured -> output_word=8'hF0.
REQ-035 Bench SHALL cover: start re-pulsed during SCAN and during DONE -> no restart, exactly one output_done, output_busy low in the cycle after DONE.
REQ-036 Bench SHALL cover: input_rst_n=0 while output_sel=4 -> next cycle IDLE, output_sel=0, output_word=8'h00, no output_done.
REQ-037 Bench SHALL cover: input_start=1 and input_rst_n=0 on the same edge -> state IDLE, output_busy=0.
